// File: rtl/fifo_pkg.sv
// Shared async FIFO definitions: pointer geometry and Gray code helpers.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int FN_W       = 32;

  function automatic logic [FN_W-1:0] bin2gray(
    input logic [FN_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down, done in log2 steps.
  function automatic logic [FN_W-1:0] gray2bin(
    input logic [FN_W-1:0] g
  );
    logic [FN_W-1:0] b;
    b = g;
    for (int s = 1; s < FN_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Output lags the input by two clock edges.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write side: Gray write pointer, memory write port,
// full/almost-full flags, fill level and sticky overflow.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int AF_MARGIN  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic [ADDR_WIDTH:0] rptr_gray,
  output logic [ADDR_WIDTH:0] wptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                wen,
  output logic                full,
  output logic                almost_full,
  output logic [ADDR_WIDTH:0] level,
  output logic                overflow
);

  import fifo_pkg::*;

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_THRESH =
    PW'((2 ** ADDR_WIDTH) - AF_MARGIN);

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wbin_d;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wptr_d;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_tgt;
  logic          wen_c;
  logic          full_q;
  logic          full_d;
  logic          af_q;
  logic          af_d;
  logic          ovf_q;
  logic          ovf_d;

  sync_2ff #(
    .WIDTH(PW)
  ) u_rptr_sync (
    .clk(clk),
    .rst(rst),
    .d_i(rptr_gray),
    .q_o(wq2_rptr)
  );

  always_comb begin
    wen_c  = inc & ~full_q;
    wbin_d = wbin_q + PW'(wen_c);
    wptr_d = PW'(bin2gray(32'(wbin_d)));
    rbin   = PW'(gray2bin(32'(wq2_rptr)));
    // Full when the next write pointer is one lap ahead of the read one.
    full_tgt = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    full_d   = (wptr_d == full_tgt);
    af_d     = ((wbin_d - rbin) >= AF_THRESH);
    ovf_d    = ovf_q | (inc & full_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q <= '0;
      wptr_q <= '0;
      full_q <= 1'b0;
      af_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wbin_q <= wbin_d;
      wptr_q <= wptr_d;
      full_q <= full_d;
      af_q   <= af_d;
      ovf_q  <= ovf_d;
    end
  end

  assign wptr        = wptr_q;
  assign waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wen         = wen_c;
  assign full        = full_q;
  assign almost_full = af_q;
  assign level       = wbin_q - rbin;
  assign overflow    = ovf_q;

endmodule
